xcvr_tx_word_splitter: RTL and testbench

//  Transmit-side counterpart of the 64->128 RX width-doubling FIFO.
//  - Accepts 128-bit words from the test-pattern/user logic through a valid/ready handshake.
//  - Buffers them in a small single-clock FIFO.
//  - Presents them to the transceiver TX parallel interface as 64-bit words, low half first,

---
 rtl/xcvr_tx_pkg.sv | 11 +
 rtl/xcvr_tx_sc_fifo.sv | 64 ++++++
 rtl/xcvr_tx_word_splitter.sv | 96 +++++++++
 tb/tb_xcvr_tx_word_splitter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/xcvr_tx_pkg.sv
// rtl/xcvr_tx_pkg.sv - shared widths, idle word default and TX word type for the TX word splitter
package xcvr_tx_pkg;

  localparam int DATA_W_IN  = 128;
  localparam int DATA_W_OUT = 64;

  localparam logic [DATA_W_OUT-1:0] IDLE_WORD_DEFAULT = 64'h07070707_07070707;

  typedef logic [DATA_W_OUT-1:0] tx_word_t;

endpackage

// File: rtl/xcvr_tx_sc_fifo.sv
// rtl/xcvr_tx_sc_fifo.sv - single-clock show-ahead FIFO of 128-bit words
module xcvr_tx_sc_fifo
  import xcvr_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W_IN-1:0]     push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W_IN-1:0]     head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [DATA_W_IN-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are AW bits wide, so the power-of-two depth wraps them for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/xcvr_tx_word_splitter.sv
// rtl/xcvr_tx_word_splitter.sv - buffers 128-bit words and emits them as 64-bit halves, low half first
module xcvr_tx_word_splitter
  import xcvr_tx_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [63:0] IDLE_WORD = IDLE_WORD_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W_IN-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    tx_enable,
  output tx_word_t                tx_data,
  output logic                    tx_dvalid,
  output logic [$clog2(DEPTH):0]  fill_level,
  input  logic                    clear_stats,
  output logic [CNT_W-1:0]        idle_cnt
);

  logic                 fifo_full, fifo_empty;
  logic [DATA_W_IN-1:0] fifo_head;
  logic                 push, pop;

  tx_word_t             tx_data_q, tx_data_d;
  logic                 tx_dvalid_q, tx_dvalid_d;
  logic                 hs_q, hs_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;

  assign in_ready = reset_n && !fifo_full;
  assign push     = in_valid && in_ready;

  xcvr_tx_sc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level),
    .head      (fifo_head)
  );

  // The head is popped only after its high half is loaded, so hs=1 implies a non-empty FIFO.
  always_comb begin
    tx_data_d   = tx_data_q;
    tx_dvalid_d = tx_dvalid_q;
    hs_d        = hs_q;
    idle_cnt_d  = idle_cnt_q;
    pop         = 1'b0;
    if (tx_enable) begin
      if (hs_q) begin
        tx_data_d   = fifo_head[DATA_W_IN-1:DATA_W_OUT];
        tx_dvalid_d = 1'b1;
        hs_d        = 1'b0;
        pop         = 1'b1;
      end else if (!fifo_empty) begin
        tx_data_d   = fifo_head[DATA_W_OUT-1:0];
        tx_dvalid_d = 1'b1;
        hs_d        = 1'b1;
      end else begin
        tx_data_d   = IDLE_WORD;
        tx_dvalid_d = 1'b0;
        if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
    end
    if (clear_stats) begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q   <= IDLE_WORD;
      tx_dvalid_q <= 1'b0;
      hs_q        <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      tx_data_q   <= tx_data_d;
      tx_dvalid_q <= tx_dvalid_d;
      hs_q        <= hs_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_dvalid = tx_dvalid_q;
  assign idle_cnt  = idle_cnt_q;

endmodule

// File: tb/tb_xcvr_tx_word_splitter.sv
// tb/tb_xcvr_tx_word_splitter.sv - self-checking bench for xcvr_tx_word_splitter
module tb_xcvr_tx_word_splitter;
  import xcvr_tx_pkg::*;

  localparam int          DEPTH    = 8;
  localparam int          CNT_W    = 8;
  localparam logic [63:0] IDLE     = 64'h07070707_07070707;
  localparam longint      IDLE_MAX = (longint'(1) << CNT_W) - 1;

  logic                   clk;
  logic                   reset_n;
  logic [127:0]           in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   tx_enable;
  logic [63:0]            tx_data;
  logic                   tx_dvalid;
  logic [$clog2(DEPTH):0] fill_level;
  logic                   clear_stats;
  logic [CNT_W-1:0]       idle_cnt;

  xcvr_tx_word_splitter #(
    .DEPTH     (DEPTH),
    .IDLE_WORD (IDLE),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .tx_dvalid   (tx_dvalid),
    .fill_level  (fill_level),
    .clear_stats (clear_stats),
    .idle_cnt    (idle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: the outgoing half-word stream as a queue; a word is stored until its
  // high half leaves, so occupancy is ceil(halves/2).
  logic [63:0] mq[$];
  longint      m_idle = 0;
  logic        last_push;
  logic        last_valid;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic         en;
    logic         clr;
    logic [63:0]  xd;
    logic         xdv;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic en, input logic clr);
    int   fill;
    logic exp_rdy;
    logic push;
    in_valid    = v;
    in_data     = d;
    tx_enable   = en;
    clear_stats = clr;
    #1;
    fill    = (mq.size() + 1) / 2;
    exp_rdy = (fill < DEPTH);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("fill_level", 64'(fill_level), 64'(fill));
    push       = v && exp_rdy;
    last_push  = push;
    last_valid = v;
    @(posedge clk);
    #1;
    if (en) begin
      if (mq.size() > 0) begin
        check("tx_data", tx_data, mq.pop_front());
        check("tx_dvalid", 64'(tx_dvalid), 64'd1);
      end else begin
        check("tx_data_idle", tx_data, IDLE);
        check("tx_dvalid_idle", 64'(tx_dvalid), 64'd0);
        if (m_idle < IDLE_MAX) m_idle++;
      end
    end
    if (clr) m_idle = 0;
    if (push) begin
      mq.push_back(d[63:0]);
      mq.push_back(d[127:64]);
    end
    check("idle_cnt", 64'(idle_cnt), 64'(m_idle));
  endtask

  initial begin
    logic [127:0] w1, w2, w3, rd;
    logic [63:0]  held;
    logic         rv;
    w1 = 128'hA1A1A1A1_A1A1A1A1_B2B2B2B2_B2B2B2B2;
    w2 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    w3 = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;

    // single word, then a word stalled by tx_enable between its halves
    tbl[0] = '{1'b1, w1,   1'b1, 1'b0, IDLE,               1'b0};
    tbl[1] = '{1'b0, '0,   1'b1, 1'b0, 64'hB2B2B2B2B2B2B2B2, 1'b1};
    tbl[2] = '{1'b0, '0,   1'b1, 1'b0, 64'hA1A1A1A1A1A1A1A1, 1'b1};
    tbl[3] = '{1'b1, w2,   1'b1, 1'b0, IDLE,               1'b0};
    tbl[4] = '{1'b0, '0,   1'b1, 1'b0, 64'h99AABBCCDDEEFF00, 1'b1};
    tbl[5] = '{1'b0, '0,   1'b0, 1'b0, 64'h99AABBCCDDEEFF00, 1'b1};
    tbl[6] = '{1'b0, '0,   1'b0, 1'b0, 64'h99AABBCCDDEEFF00, 1'b1};
    tbl[7] = '{1'b0, '0,   1'b1, 1'b0, 64'h1122334455667788, 1'b1};
    tbl[8] = '{1'b0, '0,   1'b1, 1'b0, IDLE,               1'b0};
    tbl[9] = '{1'b0, '0,   1'b0, 1'b0, IDLE,               1'b0};

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    tx_enable   = 1'b0;
    clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", tx_data, IDLE);
    check("rst_tx_dvalid", 64'(tx_dvalid), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_idle_cnt", 64'(idle_cnt), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].clr);
      check($sformatf("tbl%0d_data", i), tx_data, tbl[i].xd);
      check($sformatf("tbl%0d_dvalid", i), 64'(tx_dvalid), 64'(tbl[i].xdv));
    end

    // fill to capacity with the output stalled, offer a ninth word, then drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    end
    #1;
    check("full_fill", 64'(fill_level), 64'(DEPTH));
    check("full_ready", 64'(in_ready), 64'd0);
    rd = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) step(1'b1, rd, 1'b0, 1'b0);
    check("ninth_rejected", 64'(fill_level), 64'(DEPTH));
    for (int i = 0; i < 2 * DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drained", 64'(fill_level), 64'd0);

    // streaming: a push every other cycle keeps the link busy
    for (int i = 0; i < 20; i++) begin
      step(i[0] == 1'b0 && i < 18, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      check("stream_fill_le1", 64'(fill_level <= 1), 64'd1);
      if (i >= 1 && i <= 18) check("stream_no_idle", 64'(tx_dvalid), 64'd1);
    end

    // idle statistics
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("idle_20", 64'(idle_cnt), 64'd20);
    step(1'b0, '0, 1'b1, 1'b1);
    check("idle_clr_prio", 64'(idle_cnt), 64'd0);
    for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("idle_sat", 64'(idle_cnt), 64'(IDLE_MAX));

    // reset with three buffered words and the high half pending
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", tx_data, IDLE);
    check("mid_rst_dvalid", 64'(tx_dvalid), 64'd0);
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    mq.delete();
    m_idle = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, w3, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_low", tx_data, 64'h0123456789ABCDEF);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_high", tx_data, 64'hCAFEF00DDEADBEEF);

    // randomized traffic with protocol-compliant hold of in_data under backpressure
    rv = 1'b0;
    rd = '0;
    held = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(last_valid && !last_push)) begin
        rv = ($urandom_range(0, 99) < 55);
        rd = {$urandom, $urandom, $urandom, $urandom};
      end
      step(rv, rd, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 2 * DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("final_drain", 64'(fill_level), 64'd0);
    held = tx_data;
    step(1'b0, '0, 1'b0, 1'b0);
    check("final_hold", tx_data, held);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
